slice_add_seq: RTL and testbench
================================

SLICE_ADD_SEQ -- requirements
Module: slice_add_seq

Interface
REQ-001 Parameter NSLICE, default 4: number of 3-bit slices; operand width W = 3*NSLICE; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 cin  input  1  carry-in for add; ignored when sub=1; sampled with start.
REQ-007 a  input  W  operand A; sampled with start.
REQ-008 b  input  W  operand B; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse marking new valid sum/cout/ovf.
REQ-011 sum  output  W  result, registered, held between completions.
REQ-012 cout  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement overflow: carry into bit W-1 XOR cout.

Function
REQ-014 The block SHALL use a single 3-bit ripple-carry adder slice (three full-adder stages), time-shared across NSLICE cycles, least-significant slice first.
REQ-015 FSM states: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE -> RUN when start=1 at a clock edge; otherwise remain in IDLE.
REQ-017 On accept: latch a; latch b if sub=0, or ~b if sub=1; initialise carry register to cin if sub=0, or 1 if sub=1; clear the slice index to 0.
REQ-018 In RUN, each cycle: add slice[idx] of latched A, slice[idx] of latched B and the carry register; write the 3-bit result into the partial-sum register slice[idx]; update the carry register; increment idx.
REQ-019 RUN -> DONE at the edge that processes idx = NSLICE-1; at that same edge, load sum, cout and ovf from the completed result. ovf uses the internal carry into the MSB of the final slice.
REQ-020 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-021 Latency: if start is sampled at the edge ending cycle k, busy=1 in cycles k+1..k+NSLICE and done=1 in cycle k+NSLICE+1. Throughput is one operation per NSLICE+2 cycles.
REQ-022 start SHALL be ignored in RUN and DONE; a held start is accepted at the first edge in IDLE.
REQ-023 Changes on a, b, sub and cin after acceptance SHALL NOT affect the result.
REQ-024 sum, cout and ovf SHALL change only at the RUN -> DONE edge or on reset.
REQ-025 Arithmetic is modulo 2^W; there is no saturation.
REQ-026 busy and done SHALL never both be 1.

Reset
REQ-027 While rst=1 at a clock edge: state <= IDLE; busy, done, sum, cout and ovf <= 0; internal operand, carry, index and partial-sum registers <= 0.
REQ-028 rst takes priority over start and over every FSM transition.
REQ-029 Reset during RUN SHALL abort the operation: no done pulse follows, and the outputs read 0 from the cycle after the reset edge.

Verification (NSLICE=4, W=12; start pulsed for one cycle k)
REQ-030 a=0x7FF, b=0x001, sub=0, cin=0 -> busy in cycles k+1..k+4; done in cycle k+5; sum=0x800, cout=0, ovf=1.
REQ-031 a=0xFFF, b=0x001, sub=0, cin=0 -> sum=0x000, cout=1, ovf=0. Repeat with cin=1, b=0x000 -> same result.
REQ-032 a=0x005, b=0x007, sub=1 -> sum=0xFFE, cout=0, ovf=0. Then a=0x800, b=0x001, sub=1 -> sum=0x7FF, cout=1, ovf=1.
REQ-033 Hold start=1 continuously with a and b changing every cycle -> operations accepted only in IDLE, every NSLICE+2=6 cycles. Each result matches the operands present at its accept edge. busy and done are never high together.
REQ-034 Start an add; assert rst in cycle k+2 -> busy=0 and outputs=0 from cycle k+3. No done pulse occurs. A subsequent start completes normally.
REQ-035 After a completion, leave start low for 10 cycles -> sum, cout and ovf hold their values and done stays 0.

Source files
------------

// File: rtl/slice_add_seq.sv
// Sequential W-bit adder/subtractor: one 3-bit ripple slice reused over NSLICE
// cycles, least-significant slice first, with IDLE/RUN/DONE sequencing.
module slice_add_seq #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [3*NSLICE-1:0]   a,
  input  logic [3*NSLICE-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [3*NSLICE-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);
  localparam int W  = 3 * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q, psum, res;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [2:0]     sa, sb, ss;
  logic [3:0]     c;
  logic           last;

  // Shared 3-bit ripple slice; c[2] is the carry into the slice MSB.
  assign sa   = a_q[3*idx +: 3];
  assign sb   = b_q[3*idx +: 3];
  assign c[0] = carry;
  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign ss[i]   = sa[i] ^ sb[i] ^ c[i];
    assign c[i+1]  = (sa[i] & sb[i]) | (c[i] & (sa[i] ^ sb[i]));
  end

  assign last = (idx == IW'(NSLICE - 1));

  always_comb begin
    res             = psum;
    res[3*idx +: 3] = ss;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Subtract as a + ~b + 1; cin only matters for add.
          a_q   <= a;
          b_q   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          idx   <= '0;
        end
        RUN: begin
          psum  <= res;
          carry <= c[3];
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            sum  <= res;
            cout <= c[3];
            ovf  <= c[2] ^ c[3];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_slice_add_seq.sv
// Bench for slice_add_seq (NSLICE=4): fixed vector table, randomized ops vs an
// arithmetic model, held-start cadence, reset abort and output hold.
module tb_slice_add_seq;
  localparam int NS = 4;
  localparam int W  = 3 * NS;
  localparam logic [W-1:0] MASK = '1;

  logic clk = 1'b0, rst, start, sub, cin, busy, done, cout, ovf;
  logic [W-1:0] a, b, sum;
  int checks = 0, errors = 0;

  slice_add_seq #(.NSLICE(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s, input logic ci);
    logic [W-1:0] yy, r;
    logic [W:0]   t;
    logic         o;
    yy = s ? (~y & MASK) : y;
    t  = {1'b0, x} + {1'b0, yy} + (s ? 1 : {{W{1'b0}}, ci});
    r  = t[W-1:0];
    o  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return {t[W], o, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE with latency checks; operands scrambled after accept.
  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic s, input logic ci, input logic [W-1:0] es,
                        input logic eco, input logic eov);
    a = xa; b = xb; sub = s; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int i = 0; i < NS; i++) begin
      chk({name, " busy"}, {busy, done}, 2'b10);
      tick();
    end
    chk({name, " done"}, {busy, done}, 2'b01);
    chk({name, " sum"}, sum, es);
    chk({name, " cout/ovf"}, {cout, ovf}, {eco, eov});
    tick();
    chk({name, " idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    vec_t vt[10];
    logic [W+1:0] m;
    logic [W-1:0] qa[$], qb[$];
    logic         qs[$], qc[$];
    logic [W-1:0] hs;
    logic         hc, ho;
    int           bad, hbad;

    vt[0] = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
    vt[1] = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
    vt[2] = '{12'hFFF, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
    vt[3] = '{12'h005, 12'h007, 1'b1, 1'b0, 12'hFFE, 1'b0, 1'b0};
    vt[4] = '{12'h800, 12'h001, 1'b1, 1'b1, 12'h7FF, 1'b1, 1'b1};
    vt[5] = '{12'h123, 12'h456, 1'b0, 1'b1, 12'h57A, 1'b0, 1'b0};
    vt[6] = '{12'h800, 12'h800, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0};
    vt[7] = '{12'h000, 12'h001, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b0};
    vt[8] = '{12'h7FF, 12'h7FF, 1'b0, 1'b0, 12'hFFE, 1'b0, 1'b1};
    vt[9] = '{12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("reset outs", {busy, done, cout, ovf}, 4'b0000);
    chk("reset sum", sum, 0);
    rst = 1'b0;
    tick();

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sub, vt[i].cin,
             vt[i].s, vt[i].co, vt[i].ov);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] ra, rb;
      logic rs, rc;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      if (i < 4) begin ra = (i[0]) ? MASK : '0; rb = (i[1]) ? MASK : '0; end
      m = model(ra, rb, rs, rc);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, rc, m[W-1:0], m[W+1], m[W]);
    end

    // Held start with operands changing every cycle: accepts every NS+2 edges.
    start = 1'b1;
    bad = 0;
    for (int n = 0; n < 3 * (NS + 2); n++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      if (n % (NS + 2) == 0) begin qa.push_back(a); qb.push_back(b); qs.push_back(sub); qc.push_back(cin); end
      tick();
      if (busy && done) bad++;
      chk($sformatf("held n%0d phase", n), {busy, done},
          (n % (NS + 2) < NS) ? 2'b10 : (n % (NS + 2) == NS) ? 2'b01 : 2'b00);
      if (n % (NS + 2) == NS) begin
        m = model(qa.pop_front(), qb.pop_front(), qs.pop_front(), qc.pop_front());
        chk($sformatf("held n%0d result", n), {cout, ovf, sum}, m);
      end
    end
    start = 1'b0;
    chk("busy&done overlap", bad, 0);
    tick();

    // Reset in cycle k+2 aborts the add; no done afterwards.
    a = 12'h7FF; b = 12'h001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();            // accept edge ended cycle k, now cycle k+1
    start = 1'b0;
    tick();            // cycle k+2
    rst = 1'b1;
    tick();            // cycle k+3
    rst = 1'b0;
    chk("abort busy/done", {busy, done}, 2'b00);
    chk("abort outs", {cout, ovf, sum}, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) bad++;
      tick();
    end
    chk("abort no done", bad, 0);
    run_op("post-abort", 12'hABC, 12'h123, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0);

    // Outputs hold with start low.
    hs = sum; hc = cout; ho = ovf; hbad = 0;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      tick();
      if (done || sum !== hs || cout !== hc || ovf !== ho) hbad++;
    end
    chk("hold outputs", hbad, 0);
    chk("hold value", {cout, ovf, sum}, {1'b1, 1'b0, 12'h999});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
